// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
//   Shared types and helpers for the round-robin grant arbiter.
//   - arb_state_t : arbiter FSM state encoding
//   - MAX_REQ     : widest requester vector onehot2idx accepts
//   - onehot2idx  : index of the set bit in a one-hot vector (0 for all-zero)
// ----------------------------------------------------------------------------
package arb_pkg;

  localparam int unsigned MAX_REQ = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARB     = 2'b01,
    GRANT   = 2'b10,
    RECOVER = 2'b11
  } arb_state_t;

  // OR of the indices of all set bits. For a one-hot input this is exactly
  // the index of the set bit, and an all-zero input gives 0.
  function automatic int unsigned onehot2idx(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin pick: selects the first set bit of i_req at or
//   after the one-hot i_prio position, wrapping from N_REQ-1 to 0.
// Ports
//   i_req        in  N_REQ  request vector
//   i_prio       in  N_REQ  one-hot priority pointer
//   o_pick       out N_REQ  one-hot winner (0 when i_req == 0)
//   o_pick_valid out 1      |i_req
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_prio,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_pick_valid
);

  logic [N_REQ-1:0]   w_at_or_after;
  logic [2*N_REQ-1:0] w_dbl;
  logic [2*N_REQ-1:0] w_lowest;

  // Bits at or above the prio position: prio-1 sets every bit below it.
  assign w_at_or_after = ~(i_prio - N_REQ'(1));

  // Lower half: requests at/after prio. Upper half: all requests, which only
  // wins when the lower half is empty (the wrap-around case).
  assign w_dbl    = {i_req, i_req & w_at_or_after};
  assign w_lowest = w_dbl & (~w_dbl + (2*N_REQ)'(1));

  assign o_pick       = w_lowest[N_REQ-1:0] | w_lowest[2*N_REQ-1:N_REQ];
  assign o_pick_valid = |i_req;

endmodule

// File: rtl/rr_grant_arbiter.sv
// ----------------------------------------------------------------------------
// rr_grant_arbiter
//   Shares one fixed-latency resource among N_REQ requesters. A grant is a
//   window of at most HOLD_CYCLES cycles, followed by GAP_CYCLES recovery
//   cycles. Priority rotates round-robin via a one-hot pointer.
//   FSM: IDLE -> ARB -> GRANT -> RECOVER -> IDLE.
// Ports
//   clk          in  1             clock, posedge
//   reset_n      in  1             synchronous active-low reset
//   i_req        in  N_REQ         level requests
//   i_release    in  1             holder ends its window early (GRANT only)
//   o_gnt        out N_REQ         one-hot grant, 0 when no grant
//   o_gnt_valid  out 1             |o_gnt
//   o_gnt_id     out clog2(N_REQ)  holder index, 0 when no grant
//   o_idle       out 1             FSM in IDLE
// ----------------------------------------------------------------------------
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic                     i_release,
  output logic [N_REQ-1:0]         o_gnt,
  output logic                     o_gnt_valid,
  output logic [$clog2(N_REQ)-1:0] o_gnt_id,
  output logic                     o_idle
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  // A zero gap still needs a one-bit (unused) counter to stay legal.
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  arb_state_t         r_state;
  logic [N_REQ-1:0]   r_prio;
  logic [N_REQ-1:0]   r_winner;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;

  arb_state_t         w_state_nxt;
  logic [N_REQ-1:0]   w_prio_nxt;
  logic [N_REQ-1:0]   w_winner_nxt;
  logic [HOLD_W-1:0]  w_hold_nxt;
  logic [GAP_W-1:0]   w_gap_nxt;

  logic [N_REQ-1:0]   w_pick;
  logic               w_pick_valid;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req        (i_req),
    .i_prio       (r_prio),
    .o_pick       (w_pick),
    .o_pick_valid (w_pick_valid)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned; that is what keeps the tool from inferring latches.
    w_state_nxt  = r_state;
    w_prio_nxt   = r_prio;
    w_winner_nxt = r_winner;
    w_hold_nxt   = r_hold_cnt;
    w_gap_nxt    = r_gap_cnt;

    case (r_state)
      IDLE: begin
        if (|i_req) w_state_nxt = ARB;
      end

      ARB: begin
        if (w_pick_valid) begin
          w_state_nxt  = GRANT;
          w_winner_nxt = w_pick;
          // Next search starts just past the winner; bit N_REQ-1 wraps to 0.
          w_prio_nxt   = {w_pick[N_REQ-2:0], w_pick[N_REQ-1]};
          w_hold_nxt   = HOLD_W'(HOLD_CYCLES - 1);
        end else begin
          // Request vanished before arbitration: no grant, prio untouched.
          w_state_nxt = IDLE;
        end
      end

      GRANT: begin
        // Release and an expired window collapse into one exit.
        if (i_release || (r_hold_cnt == '0)) begin
          if (GAP_CYCLES > 0) begin
            w_state_nxt = RECOVER;
            w_gap_nxt   = GAP_W'(GAP_CYCLES - 1);
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_hold_nxt = r_hold_cnt - HOLD_W'(1);
        end
      end

      RECOVER: begin
        if (r_gap_cnt == '0) w_state_nxt = IDLE;
        else                 w_gap_nxt   = r_gap_cnt - GAP_W'(1);
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset is sampled on the clock edge only; an in-flight grant is dropped
  // at that same edge.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (!reset_n) begin
      r_state    <= IDLE;
      r_prio     <= N_REQ'(1);
      r_winner   <= '0;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_winner   <= w_winner_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gap_cnt  <= w_gap_nxt;
    end
  end

  // Outputs decode registered state only: no path from i_req/i_release.
  assign o_gnt       = (r_state == GRANT) ? r_winner : '0;
  assign o_gnt_valid = |o_gnt;
  assign o_gnt_id    = ID_W'(onehot2idx(MAX_REQ'(o_gnt)));
  assign o_idle      = (r_state == IDLE);

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_grant_arbiter
//   Directed scenarios against two arbiter instances: dut1 with defaults
//   (N_REQ=4, HOLD=3, GAP=1) and dut2 with HOLD=1, GAP=0. The stimulus pushes
//   each expected grant window {dut, id, length, start cycle} into a queue;
//   a monitor watching gnt_valid pops and compares when a window closes.
// ----------------------------------------------------------------------------
module tb_rr_grant_arbiter;
  import arb_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] req1, req2;
  logic         rel1, rel2;
  logic [N-1:0] gnt1, gnt2;
  logic         v1, v2;
  logic [1:0]   id1, id2;
  logic         idle1, idle2;

  rr_grant_arbiter #(.N_REQ(N), .HOLD_CYCLES(3), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .i_req(req1), .i_release(rel1),
    .o_gnt(gnt1), .o_gnt_valid(v1), .o_gnt_id(id1), .o_idle(idle1)
  );

  rr_grant_arbiter #(.N_REQ(N), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .i_req(req2), .i_release(rel2),
    .o_gnt(gnt2), .o_gnt_valid(v2), .o_gnt_id(id2), .o_idle(idle2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int dut;
    int id;
    int len;
    int start;
  } win_t;

  win_t exp_q[$];

  task automatic expect_win(input int dut, input int id, input int len, input int start);
    win_t e;
    e.dut = dut; e.id = id; e.len = len; e.start = start;
    exp_q.push_back(e);
  endtask

  logic         in_win [2];
  int           w_start[2];
  int           w_len  [2];
  logic [N-1:0] w_gnt  [2];

  task automatic close_win(input int k);
    win_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected_grant_dut%0d", k + 1), 32'(w_gnt[k]), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("win_dut",   k,                  e.dut);
      check("win_gnt",   32'(w_gnt[k]),      32'd1 << e.id);
      check("win_len",   w_len[k],           e.len);
      check("win_start", w_start[k],         e.start);
    end
  endtask

  initial begin : monitor
    logic [N-1:0] g;
    logic         v;
    in_win[0] = 1'b0;
    in_win[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        g = (k == 0) ? gnt1 : gnt2;
        v = (k == 0) ? v1   : v2;
        if (v) begin
          if (!in_win[k]) begin
            in_win[k]  = 1'b1;
            w_start[k] = cyc;
            w_len[k]   = 1;
            w_gnt[k]   = g;
          end else begin
            w_len[k]++;
          end
        end else if (in_win[k]) begin
          in_win[k] = 1'b0;
          close_win(k);
        end
      end
    end
  end

  // ---------------------------------------------------------------- assertions
  a1_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt1))
    else begin n_fail++; $display("FAIL sva_onehot dut1: gnt=%b", gnt1); end
  a2_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt2))
    else begin n_fail++; $display("FAIL sva_onehot dut2: gnt=%b", gnt2); end

  a1_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (dut1.r_state == GRANT && $past(dut1.r_state) == GRANT) |-> $stable(gnt1))
    else begin n_fail++; $display("FAIL sva_stable dut1: gnt=%b", gnt1); end

  a1_nognt: assert property (@(posedge clk) disable iff (!reset_n)
      (dut1.r_state != GRANT) |-> (gnt1 == '0 && id1 == '0))
    else begin n_fail++; $display("FAIL sva_nognt dut1: gnt=%b id=%0d", gnt1, id1); end
  a2_nognt: assert property (@(posedge clk) disable iff (!reset_n)
      (dut2.r_state != GRANT) |-> (gnt2 == '0 && id2 == '0))
    else begin n_fail++; $display("FAIL sva_nognt dut2: gnt=%b id=%0d", gnt2, id2); end

  a1_id: assert property (@(posedge clk) disable iff (!reset_n)
      v1 |-> (gnt1 == (N'(1) << id1)))
    else begin n_fail++; $display("FAIL sva_id dut1: gnt=%b id=%0d", gnt1, id1); end
  a2_id: assert property (@(posedge clk) disable iff (!reset_n)
      v2 |-> (gnt2 == (N'(1) << id2)))
    else begin n_fail++; $display("FAIL sva_id dut2: gnt=%b id=%0d", gnt2, id2); end

  // ---------------------------------------------------------------- stimulus
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req1 = '0; req2 = '0; rel1 = 1'b0; rel2 = 1'b0;
    tick(2);
    check("rst_gnt1",   32'(gnt1),  32'd0);
    check("rst_valid1", 32'(v1),    32'd0);
    check("rst_id1",    32'(id1),   32'd0);
    check("rst_idle",   32'({idle1, idle2}), 32'b11);
    reset_n = 1'b1;
  endtask

  // Let any window drain, then both arbiters must be idle with nothing owed.
  task automatic finish_scn(input string name);
    tick(6);
    check({name, "_idle"},    32'({idle1, idle2}), 32'b11);
    check({name, "_drained"}, exp_q.size(),        32'd0);
  endtask

  int c;

  initial begin : stim
    reset_n = 1'b0;
    req1 = '0; req2 = '0; rel1 = 1'b0; rel2 = 1'b0;
    tick(1);

    // 1: single requester held, re-granted after the gap; dropping req mid
    //    window does not shorten it.
    do_reset();
    c = cyc; req1 = 4'b0001;
    expect_win(0, 0, 3, c + 2);
    expect_win(0, 0, 3, c + 8);
    tick(9); req1 = '0;
    finish_scn("s1");

    // 2: all requesting: rotation 0,1,2,3,0.
    do_reset();
    c = cyc; req1 = 4'b1111;
    for (int i = 0; i < 5; i++) expect_win(0, i % 4, 3, c + 2 + 6 * i);
    tick(27); req1 = '0;
    finish_scn("s2");

    // 3: grant 2 moves prio to bit3; then 1001 -> 3, then wrap to 0.
    do_reset();
    c = cyc; req1 = 4'b0100;
    expect_win(0, 2, 3, c + 2);
    tick(3); req1 = '0;
    finish_scn("s3a");
    c = cyc; req1 = 4'b1001;
    expect_win(0, 3, 3, c + 2);
    expect_win(0, 0, 3, c + 8);
    tick(9); req1 = '0;
    finish_scn("s3b");

    // 4a: release on the 2nd grant cycle -> 2-cycle window, RECOVER, IDLE.
    do_reset();
    c = cyc; req1 = 4'b0001;
    expect_win(0, 0, 2, c + 2);
    tick(3); rel1 = 1'b1; req1 = '0;
    tick(1); rel1 = 1'b0;
    check("s4_recover_idle",  32'(idle1), 32'd0);
    check("s4_recover_valid", 32'(v1),    32'd0);
    tick(1);
    check("s4_back_idle", 32'(idle1), 32'd1);
    // 4b: release during ARB is ignored; release on the last cycle is a
    //     single exit with no extra cycle.
    c = cyc; req1 = 4'b0001;
    expect_win(0, 0, 3, c + 2);
    tick(1); rel1 = 1'b1;
    tick(1); rel1 = 1'b0;
    tick(2); rel1 = 1'b1; req1 = '0;
    tick(1); rel1 = 1'b0;
    check("s4b_recover_idle", 32'(idle1), 32'd0);
    tick(1);
    check("s4b_back_idle", 32'(idle1), 32'd1);
    // 4c: release in IDLE does nothing.
    rel1 = 1'b1;
    tick(2);
    check("s4c_idle", 32'(idle1), 32'd1);
    rel1 = 1'b0;
    finish_scn("s4");

    // 5: one-cycle pulse seen in IDLE, gone in ARB: no grant, prio stays 0.
    do_reset();
    c = cyc; req1 = 4'b0001;
    tick(1); req1 = '0;
    tick(1);
    check("s5_idle",  32'(idle1), 32'd1);
    check("s5_valid", 32'(v1),    32'd0);
    c = cyc; req1 = 4'b1111;
    expect_win(0, 0, 3, c + 2);
    tick(3); req1 = '0;
    finish_scn("s5");

    // 6: reset during the 2nd grant cycle drops gnt and restores prio bit0.
    do_reset();
    c = cyc; req1 = 4'b0001;
    expect_win(0, 0, 2, c + 2);
    tick(3); reset_n = 1'b0; req1 = '0;
    tick(1);
    check("s6_gnt",   32'(gnt1),  32'd0);
    check("s6_valid", 32'(v1),    32'd0);
    check("s6_id",    32'(id1),   32'd0);
    check("s6_idle",  32'(idle1), 32'd1);
    reset_n = 1'b1;
    c = cyc; req1 = 4'b1111;
    expect_win(0, 0, 3, c + 2);
    tick(3); req1 = '0;
    finish_scn("s6");

    // 6b: HOLD=1, GAP=0: 1-cycle grants straight back to IDLE.
    do_reset();
    c = cyc; req2 = 4'b0011;
    expect_win(1, 0, 1, c + 2);
    expect_win(1, 1, 1, c + 5);
    expect_win(1, 0, 1, c + 8);
    tick(3);
    check("s6b_idle",  32'(idle2), 32'd1);
    check("s6b_valid", 32'(v2),    32'd0);
    tick(5); req2 = '0;
    finish_scn("s6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
